// File: rtl/rcas_pkg.sv
// Shared types and constants for the nibble-serial add/sub sequencer.
package rcas_pkg;
   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Width of a counter that indexes nib nibbles; never narrower than one bit.
   function automatic int cnt_w(input int nib);
      return (nib <= 2) ? 1 : $clog2(nib);
   endfunction
endpackage

// File: rtl/rcas_slice4.sv
// Combinational 4-bit ripple-carry add/sub slice; inv complements y for subtract.
module rcas_slice4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       inv,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);
   logic [3:0] yi;
   logic [4:0] c;

   assign yi = y ^ {4{inv}};

   always_comb begin
      c[0] = cin;
      s    = '0;
      for (int i = 0; i < 4; i++) begin
         s[i]   = x[i] ^ yi[i] ^ c[i];
         c[i+1] = (x[i] & yi[i]) | (x[i] & c[i]) | (yi[i] & c[i]);
      end
   end

   assign cout = c[4];
endmodule

// File: rtl/rcas_seq_ctrl.sv
// WIDTH-bit add/sub sequenced LSB-nibble first through one shared 4-bit slice.
// Optional signed-overflow output ovf when RCAS_OVF_EN is defined.
module rcas_seq_ctrl
   import rcas_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] result,
   output logic             c_out
`ifdef RCAS_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int NIB = WIDTH / SLICE_W;
   localparam int CW  = cnt_w(NIB);
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
   logic              sel_q, sel_d, carry_q, carry_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [SLICE_W-1:0] sl_s;
   logic              sl_cout;

   rcas_slice4 u_slice (
      .x    (a_q[cnt_q*SLICE_W +: SLICE_W]),
      .y    (b_q[cnt_q*SLICE_W +: SLICE_W]),
      .inv  (sel_q),
      .cin  (carry_q),
      .s    (sl_s),
      .cout (sl_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sel_q   <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sel_q   <= sel_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      res_d      = res_q;
      sel_d      = sel_q;
      carry_d    = carry_q;
      cnt_d      = cnt_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               a_d     = a;
               b_d     = b;
               sel_d   = sel;
               carry_d = sel;  // +1 of the two's-complement negate enters at nibble 0
               cnt_d   = '0;
               res_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d[cnt_q*SLICE_W +: SLICE_W] = sl_s;
            carry_d = sl_cout;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = DONE;
         end
         DONE: begin
            resp_valid = 1'b1;
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign result = res_q;
   assign c_out  = carry_q;

`ifdef RCAS_OVF_EN
   logic [WIDTH-1:0] beff;
   assign beff = b_q ^ {WIDTH{sel_q}};
   assign ovf  = (a_q[WIDTH-1] == beff[WIDTH-1]) & (res_q[WIDTH-1] != a_q[WIDTH-1]);
`endif
endmodule

// File: tb/tb_rcas_seq_ctrl.sv
// Scoreboard bench for rcas_seq_ctrl (WIDTH=16): directed cases then random ops.
module tb_rcas_seq_ctrl;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid, req_ready, sel, resp_valid, resp_ready, c_out;
   logic [W-1:0] a, b, result;
`ifdef RCAS_OVF_EN
   logic         ovf;
`endif

   typedef struct {
      logic [W-1:0] r;
      logic         c;
      logic         o;
   } exp_t;

   exp_t q[$];
   exp_t em;
   int   tests = 0;
   int   fails = 0;

   rcas_seq_ctrl #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .a          (a),
      .b          (b),
      .sel        (sel),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .result     (result),
      .c_out      (c_out)
`ifdef RCAS_OVF_EN
      ,
      .ovf        (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on the operands.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      exp_t e;
      int unsigned ux, uy, full;
      ux = 32'(x);
      uy = 32'(y);
      if (!s) begin
         full = ux + uy;
         e.c  = (full >= (1 << W));
      end else begin
         full = ux - uy;
         e.c  = (ux >= uy);
      end
      e.r = full[W-1:0];
      if (!s) e.o = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
      else    e.o = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: compare every cycle a response is presented; retire it on handshake.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && resp_valid === 1'b1) begin
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_resp: got result 0x%0h with empty scoreboard", result);
         end else begin
            em = q[0];
            if (result !== em.r || c_out !== em.c) begin
               fails++;
               $display("FAIL resp: got 0x%0h/c%0b expected 0x%0h/c%0b", result, c_out, em.r, em.c);
            end
`ifdef RCAS_OVF_EN
            tests++;
            if (ovf !== em.o) begin
               fails++;
               $display("FAIL ovf: got %0b expected %0b", ovf, em.o);
            end
`endif
            if (resp_ready) void'(q.pop_front());
         end
      end
   end

   // Issue one op; hold>0 stalls resp_ready for that many DONE cycles.
   task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is, input int hold);
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("req_ready_wait", 32'(req_ready), 32'd1);
      a = ia; b = ib; sel = is; req_valid = 1'b1; resp_ready = (hold == 0);
      @(posedge clk);
      q.push_back(model(ia, ib, is));
      #1;
      req_valid = 1'b0; a = W'($urandom); b = W'($urandom); sel = 1'($urandom);
      n = 0;
      while (resp_valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("latency", 32'(n), 32'd4);
      for (int i = 0; i < hold; i++) begin
         chk("ready_in_done", 32'(req_ready), 32'd0);
         req_valid = 1'b1; a = W'($urandom); b = W'($urandom); sel = 1'($urandom);
         @(posedge clk); #1;
      end
      req_valid = 1'b0; resp_ready = 1'b1;
      @(posedge clk); #1;
      chk("resp_one_cycle", 32'(resp_valid), 32'd0);
      chk("ready_after", 32'(req_ready), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b1; a = '0; b = '0; sel = 1'b0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_c_out", 32'(c_out), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op(16'h1234, 16'h4321, 1'b0, 0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 0);
      do_op(16'h0005, 16'h0007, 1'b1, 0);
      do_op(16'h0007, 16'h0005, 1'b1, 0);
      do_op(16'hA5A5, 16'h0F0F, 1'b0, 3);
      do_op(16'h0102, 16'h0304, 1'b0, 0);

      // Reset during the second RUN cycle discards the operation.
      a = 16'h1111; b = 16'h2222; sel = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("midrst_req_ready", 32'(req_ready), 32'd1);
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      chk("midrst_result", 32'(result), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(16'h00FF, 16'h0001, 1'b0, 0);

`ifdef RCAS_OVF_EN
      do_op(16'h7FFF, 16'h0001, 1'b0, 0);
      do_op(16'h8000, 16'h0001, 1'b1, 0);
      do_op(16'h0003, 16'h0001, 1'b1, 0);
`endif

      for (int i = 0; i < 150; i++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom);
         rb = W'($urandom);
         if (i % 10 == 0) rb = ra;
         do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
      end

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
